// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle control FSM: state codes, MIPS-style
// opcode/funct constants, ALU operation codes and PC source selects.
package mcc_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE    = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_BR     = 3'b101,
        S_HALTED = 3'b110,
        S_TRAP   = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_AND  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_XNOR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_BLTZ   = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_SLTU   = 6'b101011;

    // Conditional branches resolve in BR rather than going through EXE.
    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into the ALU operation and operand
// selects used during EXE. 'legal' is high only for instructions that take
// the EXE path (R-type with a known funct, immediates, lw, sw).
module alu_op_decode
    import mcc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic       legal
);

    // Map the instruction onto ALU operation and operand selection.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        legal     = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLTU: alu_op = ALU_SLTU;
                FN_SLL: begin
                    alu_op    = ALU_SLL;
                    alu_src_a = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            alu_src_b = 1'b1;
            case (opcode)
                OP_ADDIU: begin alu_op = ALU_ADD;  ext_sel = 1'b1; end
                OP_SLTI:  begin alu_op = ALU_SLT;  ext_sel = 1'b1; end
                OP_SLTIU: begin alu_op = ALU_SLTU; ext_sel = 1'b1; end
                OP_ANDI:  alu_op = ALU_AND;
                OP_ORI:   alu_op = ALU_OR;
                OP_LW,
                OP_SW:    begin alu_op = ALU_ADD;  ext_sel = 1'b1; end
                default: begin
                    alu_src_b = 1'b0;
                    legal     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB/BR for the latched
// instruction and drives ALU opcode, datapath selects and write strobes.
// Outputs are decoded combinationally from the state register plus
// opcode/funct; every strobe and retire is held low while Reset is low.
// Build option: define ILLEGAL_TRAP_EN to send unknown opcodes/functs to a
// sticky TRAP state; otherwise they retire as a NOP.
module multi_cycle_ctrl
    import mcc_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             sign,
    output logic [2:0]       alu_op,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             ext_sel,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             wb_src,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             halted
);

    state_t     state_q;
    logic [2:0] dec_alu_op;
    logic       dec_src_a;
    logic       dec_src_b;
    logic       dec_ext_sel;
    logic       dec_legal;

    alu_op_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext_sel),
        .legal     (dec_legal)
    );

    assign state  = state_q;
    assign halted = (state_q == S_HALTED);

    // Decode datapath controls from the current state and instruction.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_PLUS4;
        ir_we     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 1'b0;
        wb_src    = 1'b0;
        retire    = 1'b0;
        if (Reset) begin
            case (state_q)
                S_IF: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_ID: begin
                    if (opcode == HALT_OPCODE) begin
                        retire = 1'b1;
                    end else if (opcode == OP_J) begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                        retire = 1'b1;
                    end else if (!is_branch(opcode) && !dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        retire = 1'b0;
`else
                        retire = 1'b1;
`endif
                    end
                end
                S_EXE: begin
                    alu_op    = dec_alu_op;
                    alu_src_a = dec_src_a;
                    alu_src_b = dec_src_b;
                    ext_sel   = dec_ext_sel;
                end
                S_MEM: begin
                    if (opcode == OP_LW) begin
                        mem_re = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = (opcode == OP_RTYPE);
                    wb_src  = (opcode == OP_LW);
                    retire  = 1'b1;
                end
                S_BR: begin
                    alu_op = ALU_SUB;
                    pc_src = PC_BRANCH;
                    pc_we  = ((opcode == OP_BEQ)  &&  zero) ||
                             ((opcode == OP_BNE)  && !zero) ||
                             ((opcode == OP_BLTZ) &&  sign);
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State sequencing and retired-instruction counter.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!Reset) begin
            state_q   <= S_IF;
            instr_cnt <= '0;
        end else begin
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            case (state_q)
                S_IF: state_q <= S_ID;
                S_ID: begin
                    if (opcode == HALT_OPCODE) begin
                        state_q <= S_HALTED;
                    end else if (opcode == OP_J) begin
                        state_q <= S_IF;
                    end else if (is_branch(opcode)) begin
                        state_q <= S_BR;
                    end else if (dec_legal) begin
                        state_q <= S_EXE;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_q <= S_TRAP;
`else
                        state_q <= S_IF;
`endif
                    end
                end
                S_EXE: begin
                    if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (opcode == OP_LW) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_IF;
                    end
                end
                S_WB:     state_q <= S_IF;
                S_BR:     state_q <= S_IF;
                S_HALTED: state_q <= S_HALTED;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: the stimulus side expands each
// instruction into its expected per-cycle control outputs and queues them;
// a negedge monitor pops one entry per cycle and compares.
module tb_multi_cycle_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        sign;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        ext_sel;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic        reg_dst;
    logic        wb_src;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] instr_cnt;
    logic        halted;

    always #5 CLK = ~CLK;

    multi_cycle_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .sign      (sign),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ext_sel   (ext_sel),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .ir_we     (ir_we),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .state     (state),
        .retire    (retire),
        .instr_cnt (instr_cnt),
        .halted    (halted)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  aop;
        logic        src_a;
        logic        src_b;
        logic        ext;
        logic        pcwe;
        logic [1:0]  pcsrc;
        logic        irwe;
        logic        mre;
        logic        mwe;
        logic        rwe;
        logic        rdst;
        logic        wbs;
        logic        ret;
        logic        hlt;
        logic [31:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state;       o.aop = alu_op;    o.src_a = alu_src_a; o.src_b = alu_src_b;
        o.ext = ext_sel;    o.pcwe = pc_we;    o.pcsrc = pc_src;    o.irwe = ir_we;
        o.mre = mem_re;     o.mwe = mem_we;    o.rwe = reg_we;      o.rdst = reg_dst;
        o.wbs = wb_src;     o.ret = retire;    o.hlt = halted;      o.cnt = instr_cnt;
        return o;
    endfunction

    // A cycle where nothing but the state/count/halted are visible.
    function automatic obs_t quiet(input logic [2:0] st);
        obs_t o = '0;
        o.st  = st;
        o.cnt = model_cnt;
        return o;
    endfunction

    // Reference ALU table: returns 1 for instructions that go through EXE.
    function automatic bit ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                   output logic [2:0] aop, output logic a,
                                   output logic b, output logic e);
        bit ok = 1'b1;
        aop = 3'd0; a = 1'b0; b = 1'b0; e = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: aop = 3'd0;
                6'h22: aop = 3'd1;
                6'h24: aop = 3'd4;
                6'h25: aop = 3'd3;
                6'h2a: aop = 3'd6;
                6'h2b: aop = 3'd5;
                6'h00: begin aop = 3'd2; a = 1'b1; end
                default: ok = 1'b0;
            endcase
        end else begin
            b = 1'b1;
            case (op)
                6'h09, 6'h23, 6'h2b: begin aop = 3'd0; e = 1'b1; end
                6'h0a: begin aop = 3'd6; e = 1'b1; end
                6'h0b: begin aop = 3'd5; e = 1'b1; end
                6'h0c: aop = 3'd4;
                6'h0d: aop = 3'd3;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Expand one instruction into its expected cycles; n = cycles consumed.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic s, output int n);
        obs_t       o;
        logic [2:0] aop;
        logic       a, b, e;
        o = quiet(3'd0); o.irwe = 1'b1; o.pcwe = 1'b1;
        exp_q.push_back(o);
        o = quiet(3'd1);
        if (op == 6'h3f) begin
            o.ret = 1'b1; exp_q.push_back(o); model_cnt++;
            for (int i = 0; i < 20; i++) begin
                o = quiet(3'd6); o.hlt = 1'b1; exp_q.push_back(o);
            end
            n = 22;
        end else if (op == 6'h02) begin
            o.pcwe = 1'b1; o.pcsrc = 2'b10; o.ret = 1'b1;
            exp_q.push_back(o); model_cnt++;
            n = 2;
        end else if (op == 6'h04 || op == 6'h05 || op == 6'h01) begin
            exp_q.push_back(o);
            o = quiet(3'd5); o.aop = 3'd1; o.pcsrc = 2'b01; o.ret = 1'b1;
            o.pcwe = (op == 6'h04 && z) || (op == 6'h05 && !z) || (op == 6'h01 && s);
            exp_q.push_back(o); model_cnt++;
            n = 3;
        end else if (ref_alu(op, fn, aop, a, b, e)) begin
            exp_q.push_back(o);
            o = quiet(3'd2); o.aop = aop; o.src_a = a; o.src_b = b; o.ext = e;
            exp_q.push_back(o);
            if (op == 6'h23) begin
                o = quiet(3'd3); o.mre = 1'b1; exp_q.push_back(o);
                o = quiet(3'd4); o.rwe = 1'b1; o.wbs = 1'b1; o.ret = 1'b1;
                exp_q.push_back(o); model_cnt++;
                n = 5;
            end else if (op == 6'h2b) begin
                o = quiet(3'd3); o.mwe = 1'b1; o.ret = 1'b1;
                exp_q.push_back(o); model_cnt++;
                n = 4;
            end else begin
                o = quiet(3'd4); o.rwe = 1'b1; o.rdst = (op == 6'h00); o.ret = 1'b1;
                exp_q.push_back(o); model_cnt++;
                n = 4;
            end
        end else begin
`ifdef ILLEGAL_TRAP_EN
            exp_q.push_back(o);
            for (int i = 0; i < 10; i++) exp_q.push_back(quiet(3'd7));
            n = 12;
`else
            o.ret = 1'b1; exp_q.push_back(o); model_cnt++;
            n = 2;
`endif
        end
    endtask

    // Issue one instruction at the start of an IF cycle and let it complete.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic s);
        int n;
        opcode = op; funct = fn; zero = z; sign = s;
        model_instr(op, fn, z, s, n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b0;
        repeat (cycles) begin
            @(negedge CLK);
            check("reset_strobes",
                  64'({ir_we, pc_we, pc_src, mem_re, mem_we, reg_we, retire}), 64'(0));
        end
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        model_cnt = '0;
        check("reset_state", 64'(state), 64'(0));
        check("reset_cnt", 64'(instr_cnt), 64'(0));
        check("reset_halted", 64'(halted), 64'(0));
    endtask

    // Monitor: compare one queued expectation per cycle.
    always @(negedge CLK) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            check($sformatf("cycle_st%0d_cnt%0h", e.st, e.cnt), 64'(a), 64'(e));
        end
    end

    logic [5:0] pool_op [0:19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h23, 6'h2b,
                                   6'h04, 6'h05, 6'h01, 6'h02, 6'h33, 6'h00};
    logic [5:0] pool_fn [0:19] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00,
                                   6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};

    initial begin
        int         idx;
        int         top;
        logic [5:0] fn;
        opcode = 6'h00; funct = 6'h20; zero = 1'b0; sign = 1'b0;
        do_reset(2);

        // Directed instructions
        run(6'h00, 6'h20, 1'b0, 1'b0);
        check("add_cnt", 64'(instr_cnt), 64'(1));
        run(6'h23, 6'h15, 1'b0, 1'b0);
        run(6'h2b, 6'h3a, 1'b1, 1'b1);
        run(6'h04, 6'h00, 1'b1, 1'b0);
        run(6'h05, 6'h00, 1'b1, 1'b0);
        run(6'h01, 6'h00, 1'b0, 1'b1);
        run(6'h04, 6'h00, 1'b0, 1'b1);
        run(6'h00, 6'h00, 1'b0, 1'b0);

        // Randomized mix
`ifdef ILLEGAL_TRAP_EN
        top = 17;
`else
        top = 19;
`endif
        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(top, 0);
            fn  = (pool_op[idx] == 6'h00) ? pool_fn[idx] : 6'($urandom);
            run(pool_op[idx], fn, 1'($urandom), 1'($urandom));
        end

        // Counter wrap at all-ones
        force dut.instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt;
        model_cnt = 32'hFFFF_FFFF;
        run(6'h02, 6'h00, 1'b0, 1'b0);
        check("wrap_cnt", 64'(instr_cnt), 64'(0));

        // Unknown opcode: trap or NOP depending on build
        run(6'h33, 6'h00, 1'b0, 1'b0);
        do_reset(1);

        // Halt, then recover through reset
        run(6'h00, 6'h25, 1'b0, 1'b0);
        run(6'h3f, 6'h00, 1'b0, 1'b0);
        check("halted_flag", 64'(halted), 64'(1));
        do_reset(2);
        run(6'h00, 6'h22, 1'b0, 1'b0);

        @(negedge CLK);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("final_cnt", 64'(instr_cnt), 64'(model_cnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
